// File: rtl/cpu_sequencer_pkg.sv
// rtl/cpu_sequencer_pkg.sv - shared control-word layout and sequencer state encoding
package cpu_sequencer_pkg;

  localparam int SIG_WIDTH = 42;

  localparam int IR_LOAD  = 39;
  localparam int STEP_RST = 40;
  localparam int HALT     = 41;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } seq_state_t;

endpackage

// File: rtl/cpu_sequencer_step_counter.sv
// rtl/cpu_sequencer_step_counter.sv - modulo-STEPS microstep counter with enable and sync clear
module cpu_sequencer_step_counter #(
  parameter int STEP_W = 3,
  parameter int STEPS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  output logic [STEP_W-1:0] step
);

  localparam logic [STEP_W-1:0] LAST = STEP_W'(STEPS - 1);

  // Wrap at STEPS-1 rather than at the natural 2**STEP_W rollover
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      step <= '0;
    else if (clr)
      step <= '0;
    else if (en)
      step <= (step == LAST) ? '0 : step + 1'b1;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - microcode sequencer: IR, microstep and RUN/HALTED control word generator
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int               DATA_W       = 8,
  parameter int               OPC_W        = 8,
  parameter int               STEP_W       = 3,
  parameter int               STEPS        = 8,
  parameter int               SIG_W        = SIG_WIDTH,
  parameter logic [SIG_W-1:0] SIG_IDLE     = '0,
  parameter int               IR_LOAD_BIT  = IR_LOAD,
  parameter int               STEP_RST_BIT = STEP_RST,
  parameter int               HALT_BIT     = HALT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       bus_in,
  input  logic                    mem_wait,
  input  logic                    run,
  output logic [OPC_W+STEP_W-1:0] ucode_addr,
  input  logic [SIG_W-1:0]        ucode_word,
  output logic [SIG_W-1:0]        signals,
  output logic [OPC_W-1:0]        ir,
  output logic [STEP_W-1:0]       step,
  output logic                    halted
);

  seq_state_t state;
  logic       advance;
  logic       resume;
  logic       step_clr;

  assign advance  = (state == RUN) && !mem_wait;
  assign resume   = (state == HALTED) && run;
  // Halting also parks the step at 0 so resume restarts the current instruction
  assign step_clr = advance && (signals[STEP_RST_BIT] || signals[HALT_BIT]);

  assign ucode_addr = {ir, step};

  cpu_sequencer_step_counter #(
    .STEP_W(STEP_W),
    .STEPS (STEPS)
  ) u_step_counter (
    .clk (clk),
    .rst (reset),
    .en  (advance || resume),
    .clr (step_clr),
    .step(step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      signals <= SIG_IDLE;
      ir      <= '0;
      halted  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (!mem_wait) begin
            if (signals[IR_LOAD_BIT])
              ir <= bus_in[OPC_W-1:0];
            if (signals[HALT_BIT]) begin
              state   <= HALTED;
              halted  <= 1'b1;
              signals <= SIG_IDLE;
            end else begin
              signals <= ucode_word;
            end
          end
        end
        HALTED: begin
          if (run) begin
            state   <= RUN;
            halted  <= 1'b0;
            signals <= ucode_word;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

  localparam int STEPS = 8;

  logic        clk = 1'b0;
  logic        reset, mem_wait, run;
  logic [7:0]  bus_in;
  logic [10:0] ucode_addr;
  logic [41:0] ucode_word, signals;
  logic [7:0]  ir;
  logic [2:0]  step;
  logic        halted;

  logic        rst2, mw2, run2;
  logic [7:0]  bus2;
  logic [10:0] addr2;
  logic [41:0] word2, sig2;
  logic [7:0]  ir2;
  logic [2:0]  step2;
  logic        halted2;

  logic [41:0] rom  [0:2047];
  logic [41:0] rom2 [0:2047];

  int n_chk  = 0;
  int n_fail = 0;

  logic        m_halted;
  logic [7:0]  m_ir;
  int          m_step;
  logic [41:0] m_sig;

  typedef struct {
    logic       mw;
    logic       rn;
    logic [7:0] bus;
    int         st;
    logic [7:0] ir;
    logic       hl;
  } vec_t;
  vec_t tbl [19];

  always #5 clk = ~clk;

  assign ucode_word = rom[ucode_addr];
  assign word2      = rom2[addr2];

  cpu_sequencer dut (
    .clk(clk), .reset(reset), .bus_in(bus_in), .mem_wait(mem_wait), .run(run),
    .ucode_addr(ucode_addr), .ucode_word(ucode_word), .signals(signals),
    .ir(ir), .step(step), .halted(halted)
  );

  cpu_sequencer #(.STEPS(5), .SIG_IDLE(42'h00000000C05)) dut5 (
    .clk(clk), .reset(rst2), .bus_in(bus2), .mem_wait(mw2), .run(run2),
    .ucode_addr(addr2), .ucode_word(word2), .signals(sig2),
    .ir(ir2), .step(step2), .halted(halted2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_halted = 1'b0;
    m_ir     = 8'h00;
    m_step   = 0;
    m_sig    = 42'h0;
  endtask

  // One clock of the architectural rules: word at {ir,step} shows up next cycle,
  // control bits in the currently shown word act on this edge.
  task automatic model_edge();
    logic [41:0] w;
    logic        do_load, do_rst, do_halt;
    w       = rom[{m_ir, 3'(m_step)}];
    do_load = m_sig[39];
    do_rst  = m_sig[40];
    do_halt = m_sig[41];
    if (!m_halted) begin
      if (!mem_wait) begin
        if (do_load) m_ir = bus_in;
        if (do_halt) begin
          m_halted = 1'b1;
          m_sig    = 42'h0;
          m_step   = 0;
        end else begin
          m_sig  = w;
          m_step = do_rst ? 0 : (m_step + 1) % STEPS;
        end
      end
    end else if (run) begin
      m_halted = 1'b0;
      m_sig    = rom[{m_ir, 3'd0}];
      m_step   = 1 % STEPS;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".signals"}, 64'(signals), 64'(m_sig));
    chk({tag, ".step"}, 64'(step), 64'(m_step));
    chk({tag, ".ir"}, 64'(ir), 64'(m_ir));
    chk({tag, ".halted"}, 64'(halted), 64'(m_halted));
    chk({tag, ".ucode_addr"}, 64'(ucode_addr), 64'({m_ir, 3'(m_step)}));
  endtask

  task automatic cyc(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #2;
    model_reset();
    check_model(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic fill_rom(input bit ctrl);
    logic [41:0] w;
    for (int a = 0; a < 2048; a++) begin
      w = {10'($urandom), 32'($urandom)};
      if (ctrl)
        w[41:39] = {($urandom_range(15) == 0), ($urandom_range(7) == 0), ($urandom_range(7) == 0)};
      else
        w[41:39] = 3'b000;
      rom[a] = w;
      w = {10'($urandom), 32'($urandom)};
      w[41:39] = 3'b000;
      rom2[a] = w;
    end
  endtask

  initial begin
    reset = 1'b1; mem_wait = 1'b0; run = 1'b0; bus_in = 8'h00;
    rst2  = 1'b1; mw2 = 1'b0; run2 = 1'b0; bus2 = 8'h00;
    fill_rom(1'b0);

    // STEPS=5 instance with a non-zero idle word
    @(posedge clk);
    #1;
    chk("p5.reset.signals", 64'(sig2), 64'h00000000C05);
    chk("p5.reset.step", 64'(step2), 64'd0);
    rst2 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("p5.wrap%0d.step", k), 64'(step2), 64'(k % 5));
      chk($sformatf("p5.wrap%0d.signals", k), 64'(sig2), 64'(rom2[{8'h00, 3'(k - 1)}]));
    end
    rom2[{8'h00, 3'd1}][41] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("p5.halt.halted", 64'(halted2), 64'd1);
    chk("p5.halt.signals", 64'(sig2), 64'h00000000C05);
    chk("p5.halt.step", 64'(step2), 64'd0);
    rst2 = 1'b1;

    // Directed walk: IR load, early step reset, stall, halt, resume
    rom[{8'h00, 3'd1}][39] = 1'b1;
    rom[{8'hA5, 3'd3}][40] = 1'b1;
    rom[{8'hA5, 3'd0}][39] = 1'b1;
    rom[{8'h11, 3'd4}][41] = 1'b1;
    tbl[0]  = '{1'b0, 1'b0, 8'hA5, 1, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 8'hA5, 2, 8'h00, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 8'hA5, 3, 8'hA5, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 8'hA5, 4, 8'hA5, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 8'hA5, 0, 8'hA5, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 8'hA5, 1, 8'hA5, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 8'h11, 1, 8'hA5, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 8'h11, 1, 8'hA5, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 8'h11, 1, 8'hA5, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 8'h11, 2, 8'h11, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'h11, 3, 8'h11, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 8'h11, 4, 8'h11, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 8'h11, 5, 8'h11, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 8'h11, 0, 8'h11, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 8'h11, 0, 8'h11, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 8'h22, 0, 8'h11, 1'b1};
    tbl[16] = '{1'b1, 1'b0, 8'h22, 0, 8'h11, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 8'h22, 1, 8'h11, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 8'h22, 2, 8'h11, 1'b0};

    do_reset("dir.reset");
    for (int i = 0; i < 19; i++) begin
      mem_wait = tbl[i].mw;
      run      = tbl[i].rn;
      bus_in   = tbl[i].bus;
      cyc($sformatf("dir%0d", i));
      chk($sformatf("dir%0d.step_tbl", i), 64'(step), 64'(tbl[i].st));
      chk($sformatf("dir%0d.ir_tbl", i), 64'(ir), 64'(tbl[i].ir));
      chk($sformatf("dir%0d.halted_tbl", i), 64'(halted), 64'(tbl[i].hl));
    end
    chk("dir.resume.signals", 64'(rom[{8'h11, 3'd1}]), 64'(signals));
    run = 1'b0;

    // Asynchronous reset in the middle of an instruction
    do_reset("mid.reset0");
    bus_in = 8'h3C;
    for (int i = 0; i < 5; i++) cyc($sformatf("mid%0d", i));
    chk("mid.pre.step", 64'(step), 64'd5);
    chk("mid.pre.ir", 64'(ir), 64'h3C);
    #3;
    reset = 1'b1;
    #1;
    chk("mid.async.signals", 64'(signals), 64'd0);
    chk("mid.async.step", 64'(step), 64'd0);
    chk("mid.async.ir", 64'(ir), 64'd0);
    chk("mid.async.halted", 64'(halted), 64'd0);
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
    cyc("mid.first");
    chk("mid.first.rom0", 64'(signals), 64'(rom[11'h000]));

    // Randomised ROM and inputs against the reference model
    fill_rom(1'b1);
    do_reset("rnd.reset");
    for (int i = 0; i < 600; i++) begin
      mem_wait = ($urandom_range(3) == 0);
      run      = ($urandom_range(3) == 0);
      bus_in   = 8'($urandom);
      if ($urandom_range(80) == 0)
        do_reset($sformatf("rnd%0d.reset", i));
      else
        cyc($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Parametrised microcode sequencer that generates the CPU control word, the successor of the fixed 42-bit signal register. It holds the instruction register (IR), a microstep counter and a RUN/HALTED state machine. It addresses an external microcode ROM with {IR, step} and registers the returned word onto `signals`, which drives PC, register, ALU and bus-buffer controls. It adds stall (memory wait), halt/resume and early step reset, none of which the current design has.

Parameters:
DATA_W, 8, width of bus_in (data bus)
OPC_W, 8, IR/opcode width (must be <= DATA_W; IR takes bus_in[OPC_W-1:0])
STEP_W, 3, microstep counter width
STEPS, 8, microsteps per instruction (2..2**STEP_W); step wraps after STEPS-1
SIG_W, 42, control word width
SIG_IDLE, {SIG_W{1'b0}}, inactive control word (encodes mixed polarity of active-low controls)
IR_LOAD_BIT, 39, signals bit: load IR from bus_in
STEP_RST_BIT, 40, signals bit: next step is 0
HALT_BIT, 41, signals bit: enter HALTED

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
bus_in  in  DATA_W  shared data bus, sampled for IR load
mem_wait  in  1  stall request; freezes the sequencer while high
run  in  1  resume pulse; leaves HALTED
ucode_addr  out  OPC_W+STEP_W  combinational {ir, step} to microcode ROM
ucode_word  in  SIG_W  ROM data for ucode_addr, valid the same cycle (async ROM)
signals  out  SIG_W  registered control word
ir  out  OPC_W  instruction register
step  out  STEP_W  current microstep
halted  out  1  high in HALTED

Behaviour:
- Reset (async, any time, including mid-instruction or mid-stall): state=RUN, signals=SIG_IDLE, ir=0, step=0, halted=0. First ROM word is registered at the first rising edge after reset deasserts.
- ucode_addr = {ir, step}, purely combinational; no other output is combinational.
- Latency: the word at address A in cycle N appears on signals in cycle N+1. Control actions (IR load, step reset, halt) act on the edge that ends the cycle in which signals shows the bit.
- RUN, mem_wait=0, each rising edge:
  - signals <= ucode_word.
  - step <= 0 if signals[STEP_RST_BIT] or step==STEPS-1, else step+1.
  - ir <= bus_in[OPC_W-1:0] if signals[IR_LOAD_BIT].
  - If signals[HALT_BIT]: state <= HALTED, signals <= SIG_IDLE, step <= 0, ir unchanged; the IR load in the same cycle still happens.
- RUN, mem_wait=1: signals, step, ir and state all hold. Halt, IR load and step reset are deferred until mem_wait falls.
- HALTED: signals=SIG_IDLE, step=0, halted=1; mem_wait is ignored.
  - run=1 at an edge: state <= RUN, halted <= 0, signals <= ucode_word for {ir, 0}. Execution resumes at step 0 of the current IR.
  - run is ignored in RUN.
- Simultaneous STEP_RST_BIT at step STEPS-1: next step is 0 (no conflict). IR_LOAD_BIT with STEP_RST_BIT: both take effect.
- Step arithmetic is unsigned modulo STEPS, not 2**STEP_W.
- halted is registered and mirrors state.

Decomposition:
- Shared package/include (extends include/signals.v): control-bit index constants (IR_LOAD, STEP_RST, HALT, plus the existing PC_* and REG_* indices), SIG_W, and the state encoding localparams RUN=1'b0, HALTED=1'b1.
- One natural sub-module, step_counter: modulo-STEPS counter with enable, sync clear and async reset. Everything else lives in the top module.

Test Plan:
- Reset: assert reset mid-instruction at step=5 with ir=8'h3C -> same cycle signals=SIG_IDLE, step=0, ir=0, halted=0. After release, the edge loads ucode_word[{0,0}].
- Sequencing and wrap: ROM with no control bits, STEPS=8 -> step runs 0..7,0. signals equals the ROM word for the previous cycle's address every cycle.
- IR load and early reset: ROM step1 sets IR_LOAD, bus_in=8'hA5; step3 sets STEP_RST -> ir=8'hA5 after the edge ending step 2's signals cycle. step goes 4->0, and ucode_addr={8'hA5, 0}.
- Stall: mem_wait=1 for 3 cycles while signals has IR_LOAD, bus_in=8'h11 -> signals, step and ir unchanged for 3 cycles. ir=8'h11 on the first edge after mem_wait falls.
- Halt/resume: HALT_BIT word at step 4 -> halted=1, signals=SIG_IDLE, step=0. mem_wait toggling changes nothing. A run pulse then gives halted=0 and signals=ROM[{ir, 0}].
- Parametrisation: STEPS=5, STEP_W=3, SIG_IDLE=42'h00000000C05 -> step wraps 4->0, and reset and HALTED drive 42'h00000000C05.
